// File: rtl/observer_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; reset value is
// chosen per input so an idle line does not glitch out of reset.
module observer_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic meta_q, sync_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/observer_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-byte holding register on a
// valid/ready handshake, and single-cycle framing-error / overrun pulses.
module observer_uart_rx #(
   parameter int CLK_FREQ_HZ = 16000000,
   parameter int BAUD        = 57600
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun
);

   localparam int DIV  = CLK_FREQ_HZ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);

   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   generate
      if (DIV < 4) begin : g_bad_div
         $error("observer_uart_rx: CLK_FREQ_HZ/BAUD must be at least 4");
      end
   endgenerate

   logic          rx_s;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          deliver;

   observer_sync2 #(.RST_VAL(1'b1)) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_rx),
      .o_q   (rx_s)
   );

   // Receive sequencer; cnt free-runs down to 0 and each state acts on cnt==0.
   always_comb begin
      state_d  = state_q;
      cnt_d    = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      ferr_d   = 1'b0;
      deliver  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               cnt_d   = HALF_M1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               if (!rx_s) begin
                  cnt_d    = DIV_M1;
                  bitcnt_d = 3'd0;
                  state_d  = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = DIV_M1;
               if (bitcnt_q == 3'd7) state_d = S_STOP;
               else                  bitcnt_d = bitcnt_q + 3'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  deliver = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Holding register: a completed byte only lands if the slot is free or
   // being drained this same cycle; otherwise the new byte is dropped.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (deliver) begin
         if (!valid_q || i_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bitcnt_q <= 3'd0;
         shift_q  <= 8'd0;
         data_q   <= 8'd0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;
   assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_observer_uart_rx.sv
// Directed bench for observer_uart_rx at DIV=16, HALF=8 (16 MHz / 1 Mbit/s).
module tb_observer_uart_rx;

   localparam int CLKP  = 100;   // clock period in time units
   localparam int DIV   = 16;
   localparam int LAT   = 8 + 9 * DIV + 3;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_rx  = 1'b1;
   logic       i_ready = 1'b1;
   logic [7:0] o_data;
   logic       o_valid, o_frame_err, o_overrun;

   int checks = 0;
   int failures = 0;

   observer_uart_rx #(.CLK_FREQ_HZ(16000000), .BAUD(1000000)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun)
   );

   always #(CLKP/2) i_clk = ~i_clk;

   int         cyc = 0;
   int         rise_cyc = -1;
   logic       prev_valid = 1'b0;
   logic [7:0] got[$];
   int         n_ferr = 0, n_ovr = 0, n_both = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Monitor on the falling edge: accepted bytes, error pulses, first rise of o_valid.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_valid && i_ready) got.push_back(o_data);
         if (o_frame_err) n_ferr++;
         if (o_overrun) n_ovr++;
         if (o_frame_err && o_overrun) n_both++;
         if (o_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
      end
      prev_valid = o_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Clock-aligned frame, DIV cycles per bit; call at posedge+1.
   task automatic send_sync(input logic [7:0] b, input logic stopb);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         i_rx = fr[i];
         clk_n(DIV);
      end
      i_rx = 1'b1;
   endtask

   // Free-running frame with an arbitrary bit period in time units.
   task automatic send_async(input logic [7:0] b, input int bit_t);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         i_rx = fr[i];
         #(bit_t);
      end
      i_rx = 1'b1;
   endtask

   task automatic clear_mon();
      got.delete();
      n_ferr = 0;
      n_ovr = 0;
      n_both = 0;
   endtask

   task automatic expect_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input int n);
      logic [7:0] ex[3];
      ex[0] = e0; ex[1] = e1; ex[2] = e2;
      chk({tag, "_count"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), got[i], ex[i]);
   endtask

   initial begin
      int cyc0;
      int bits[3];
      logic [7:0] sweep_b[3];
      logic [7:0] e7;

      clk_n(4);
      i_rst = 1'b0;
      clk_n(1);
      chk("reset_outputs", {o_data, o_valid, o_frame_err, o_overrun}, 11'd0);
      clk_n(10);

      // Single byte with i_ready low: timing, hold, then one-cycle drain.
      i_ready = 1'b0;
      clear_mon();
      rise_cyc = -1;
      cyc0 = cyc;
      send_sync(8'hA5, 1'b1);
      for (int k = 0; k < 100 && rise_cyc < 0; k++) clk_n(1);
      chk("single_timeout", (rise_cyc >= 0), 1);
      chk("single_latency", rise_cyc - cyc0, LAT);
      chk("single_data", o_data, 8'hA5);
      clk_n(20);
      chk("single_hold_valid", o_valid, 1'b1);
      i_ready = 1'b1;
      clk_n(1);
      @(negedge i_clk);
      chk("single_clear", o_valid, 1'b0);
      chk("single_data_kept", o_data, 8'hA5);
      clk_n(1);
      expect_bytes("single", 8'hA5, 8'h00, 8'h00, 1);

      // Back-to-back frames, one stop bit each.
      clear_mon();
      send_sync(8'h00, 1'b1);
      send_sync(8'hFF, 1'b1);
      send_sync(8'h55, 1'b1);
      clk_n(40);
      expect_bytes("b2b", 8'h00, 8'hFF, 8'h55, 3);
      chk("b2b_errors", n_ferr + n_ovr, 0);

      // Overrun: second byte dropped, first retained.
      clear_mon();
      i_ready = 1'b0;
      send_sync(8'h11, 1'b1);
      send_sync(8'h22, 1'b1);
      clk_n(40);
      chk("ovr_valid", o_valid, 1'b1);
      chk("ovr_data", o_data, 8'h11);
      chk("ovr_pulses", n_ovr, 1);
      chk("ovr_no_ferr", n_ferr, 0);
      i_ready = 1'b1;
      clk_n(3);
      expect_bytes("ovr_drain", 8'h11, 8'h00, 8'h00, 1);
      chk("ovr_cleared", o_valid, 1'b0);

      // Framing error followed by a held-low break.
      clear_mon();
      send_sync(8'h3C, 1'b0);
      i_rx = 1'b0;
      clk_n(40);
      i_rx = 1'b1;
      clk_n(200);
      chk("ferr_pulses", n_ferr, 1);
      chk("ferr_no_byte", got.size(), 0);
      chk("ferr_no_valid", o_valid, 1'b0);
      chk("ferr_no_ovr", n_ovr, 0);
      send_sync(8'h3C, 1'b1);
      clk_n(40);
      expect_bytes("ferr_after", 8'h3C, 8'h00, 8'h00, 1);
      chk("ferr_after_pulses", n_ferr, 1);

      // Short low glitch is rejected; receiver is back in IDLE afterwards.
      clear_mon();
      i_rx = 1'b0;
      clk_n(3);
      i_rx = 1'b1;
      clk_n(200);
      chk("glitch_quiet", got.size() + n_ferr + n_ovr, 0);
      send_sync(8'h96, 1'b1);
      clk_n(40);
      expect_bytes("glitch_after", 8'h96, 8'h00, 8'h00, 1);

      // Baud mismatch sweep: -3%, nominal, +3%.
      clear_mon();
      bits[0] = 1552; bits[1] = 1600; bits[2] = 1648;
      sweep_b[0] = 8'hC3; sweep_b[1] = 8'h5A; sweep_b[2] = 8'h81;
      #37;
      for (int s = 0; s < 3; s++) begin
         send_async(sweep_b[s], bits[s]);
         #(30 * CLKP + 13);
      end
      clk_n(10);
      expect_bytes("sweep", 8'hC3, 8'h5A, 8'h81, 3);
      chk("sweep_errors", n_ferr + n_ovr, 0);

      // Reset during data bit 4 with a byte parked in the holding register.
      clear_mon();
      i_ready = 1'b0;
      send_sync(8'h42, 1'b1);
      clk_n(10);
      chk("rst_pre_valid", o_valid, 1'b1);
      e7 = 8'hE7;
      i_rx = 1'b0;
      clk_n(DIV);
      for (int i = 0; i < 4; i++) begin
         i_rx = e7[i];
         clk_n(DIV);
      end
      i_rx = e7[4];
      clk_n(DIV / 2);
      i_rst = 1'b1;
      i_rx = 1'b1;
      clk_n(1);
      @(negedge i_clk);
      chk("rst_mid_outputs", {o_data, o_valid, o_frame_err, o_overrun}, 11'd0);
      clk_n(1);
      i_rst = 1'b0;
      i_ready = 1'b1;
      clk_n(200);
      chk("rst_quiet", got.size() + n_ferr + n_ovr, 0);
      send_sync(8'h7E, 1'b1);
      clk_n(40);
      expect_bytes("rst_after", 8'h7E, 8'h00, 8'h00, 1);

      chk("never_both_pulses", n_both, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
